// File: rtl/obstacle_field_if.sv
// Bundle between the frame-tick/game-control side and the obstacle field.
// The game controller side drives the master modport; obstacle_field takes the slave modport.
`timescale 1ns/1ps
interface obstacle_field_if #(
  parameter int NUM_OBS = 3,
  parameter int X_W     = 11,
  parameter int Y_W     = 9
);
  logic                   tick;
  logic                   run;
  logic                   freeze;
  logic [2:0]             speed;
  logic [NUM_OBS*X_W-1:0] obs_x;
  logic [NUM_OBS*Y_W-1:0] obs_gap_top;
  logic [NUM_OBS*Y_W-1:0] obs_gap_bot;
  logic                   active;
  logic                   frozen;
  logic                   pass;
  logic [7:0]             score;

  modport master (
    output tick, run, freeze, speed,
    input  obs_x, obs_gap_top, obs_gap_bot, active, frozen, pass, score
  );

  modport slave (
    input  tick, run, freeze, speed,
    output obs_x, obs_gap_top, obs_gap_bot, active, frozen, pass, score
  );
endinterface

// File: rtl/obstacle_field.sv
// Ring of scrolling pipe obstacles with idle/run/frozen game FSM, pass pulse and saturating score.
// All outputs registered, one cycle after tick; no backpressure (tick is a free-running strobe).
`timescale 1ns/1ps
module obstacle_field #(
  parameter int         NUM_OBS  = 3,
  parameter int         X_W      = 11,
  parameter int         Y_W      = 9,
  parameter int         SCREEN_W = 640,
  parameter int         SPACING  = 240,
  parameter int         GAP      = 120,
  parameter int         Y_MIN    = 40,
  parameter int         Y_MAX    = 320,
  parameter int         BIRD_X   = 100,
  parameter logic [8:0] SEED     = 9'h1A5
) (
  input logic             clk,
  input logic             reset,
  obstacle_field_if.slave bus
);

  localparam int         RING  = NUM_OBS * SPACING;
  localparam logic [8:0] RANGE = 9'(Y_MAX - Y_MIN + 1);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  state_t                          state;
  logic [8:0]                      lfsr;
  logic [NUM_OBS-1:0][X_W-1:0]     x_q;
  logic [NUM_OBS-1:0][Y_W-1:0]     top_q;
  logic [NUM_OBS-1:0][Y_W-1:0]     bot_q;
  logic                            active_q;
  logic                            frozen_q;
  logic                            pass_q;
  logic [7:0]                      score_q;

  logic [X_W-1:0]                  s;
  logic [Y_W-1:0]                  new_top;
  logic [NUM_OBS-1:0][X_W-1:0]     x_next;
  logic [NUM_OBS-1:0]              respawn;
  logic                            crossed;

  assign s       = (bus.speed == 3'd0) ? X_W'(1) : X_W'(bus.speed);
  assign new_top = Y_W'(Y_MIN) + Y_W'(lfsr % RANGE);

  // Every respawning obstacle shares the single LFSR sample of this cycle.
  always_comb begin
    crossed = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      respawn[i] = (x_q[i] < s);
      x_next[i]  = respawn[i] ? (x_q[i] + X_W'(RING) - s) : (x_q[i] - s);
      if (!respawn[i] && (x_q[i] >= X_W'(BIRD_X)) && (x_next[i] < X_W'(BIRD_X)))
        crossed = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lfsr     <= SEED;
      active_q <= 1'b0;
      frozen_q <= 1'b0;
      pass_q   <= 1'b0;
      score_q  <= 8'd0;
      for (int i = 0; i < NUM_OBS; i++) begin
        x_q[i]   <= X_W'(SCREEN_W + i * SPACING);
        top_q[i] <= Y_W'(Y_MIN);
        bot_q[i] <= Y_W'(Y_MIN + GAP);
      end
    end else begin
      lfsr   <= (lfsr == 9'd0) ? SEED : {lfsr[7:0], lfsr[8] ^ lfsr[4]};
      pass_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run) begin
            state    <= RUN;
            active_q <= 1'b1;
            score_q  <= 8'd0;
            for (int i = 0; i < NUM_OBS; i++) begin
              x_q[i]   <= X_W'(SCREEN_W + i * SPACING);
              top_q[i] <= Y_W'(Y_MIN);
              bot_q[i] <= Y_W'(Y_MIN + GAP);
            end
          end
        end
        RUN: begin
          if (bus.freeze) begin
            state    <= FROZEN;
            active_q <= 1'b0;
            frozen_q <= 1'b1;
          end else if (!bus.run) begin
            state    <= IDLE;
            active_q <= 1'b0;
          end else if (bus.tick) begin
            for (int i = 0; i < NUM_OBS; i++) begin
              x_q[i] <= x_next[i];
              if (respawn[i]) begin
                top_q[i] <= new_top;
                bot_q[i] <= new_top + Y_W'(GAP);
              end
            end
            if (crossed) begin
              pass_q <= 1'b1;
              if (score_q != 8'hFF) score_q <= score_q + 8'd1;
            end
          end
        end
        FROZEN: begin
          if (!bus.run) begin
            state    <= IDLE;
            frozen_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          active_q <= 1'b0;
          frozen_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.obs_x       = x_q;
  assign bus.obs_gap_top = top_q;
  assign bus.obs_gap_bot = bot_q;
  assign bus.active      = active_q;
  assign bus.frozen      = frozen_q;
  assign bus.pass        = pass_q;
  assign bus.score       = score_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field: scrolling, pass/score, respawn heights, speed, freeze and reset.
`timescale 1ns/1ps
module tb_obstacle_field;
  localparam int NUM_OBS = 3;
  localparam int X_W     = 11;
  localparam int Y_W     = 9;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] m_lfsr;

  obstacle_field_if #(.NUM_OBS(NUM_OBS), .X_W(X_W), .Y_W(Y_W)) ifc ();

  obstacle_field dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Reference x^9+x^5+1 Fibonacci generator, shifting left with feedback into bit 0.
  always @(posedge clk or posedge reset) begin
    if (reset)              m_lfsr <= 9'h1A5;
    else if (m_lfsr == 9'd0) m_lfsr <= 9'h1A5;
    else                    m_lfsr <= {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
  end

  function automatic int ox(input int i);
    return int'(ifc.obs_x[i*X_W +: X_W]);
  endfunction
  function automatic int gt(input int i);
    return int'(ifc.obs_gap_top[i*Y_W +: Y_W]);
  endfunction
  function automatic int gb(input int i);
    return int'(ifc.obs_gap_bot[i*Y_W +: Y_W]);
  endfunction

  task automatic run_ticks(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (ifc.pass === 1'b1) pulses++;
      ifc.tick = 1'b1;
    end
    @(negedge clk);
    if (ifc.pass === 1'b1) pulses++;
    ifc.tick = 1'b0;
  endtask

  task automatic tick_once(output logic [8:0] lf);
    @(negedge clk);
    lf = m_lfsr;
    ifc.tick = 1'b1;
    @(negedge clk);
    ifc.tick = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ifc.tick = 1'b0; ifc.run = 1'b0; ifc.freeze = 1'b0; ifc.speed = 3'd1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ifc.obs_x !== {11'd1120, 11'd880, 11'd640}) begin errors++; $display("FAIL reset_obs_x: got %h want %h", ifc.obs_x, {11'd1120, 11'd880, 11'd640}); end
    checks++; if (ifc.obs_gap_top !== {9'd40, 9'd40, 9'd40}) begin errors++; $display("FAIL reset_gap_top: got %h want %h", ifc.obs_gap_top, {9'd40, 9'd40, 9'd40}); end
    checks++; if (ifc.obs_gap_bot !== {9'd160, 9'd160, 9'd160}) begin errors++; $display("FAIL reset_gap_bot: got %h want %h", ifc.obs_gap_bot, {9'd160, 9'd160, 9'd160}); end
    checks++; if ({ifc.active, ifc.frozen, ifc.pass} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {ifc.active, ifc.frozen, ifc.pass}); end
    checks++; if (ifc.score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", ifc.score); end
  endtask

  task automatic test_start;
    @(negedge clk); ifc.run = 1'b1;
    @(negedge clk);
    checks++; if ({ifc.active, ifc.frozen} !== 2'b10) begin errors++; $display("FAIL start_flags: got %b want 10", {ifc.active, ifc.frozen}); end
    checks++; if (ifc.obs_x !== {11'd1120, 11'd880, 11'd640}) begin errors++; $display("FAIL start_obs_x: got %h want %h", ifc.obs_x, {11'd1120, 11'd880, 11'd640}); end
    checks++; if (ifc.score !== 8'd0) begin errors++; $display("FAIL start_score: got %0d want 0", ifc.score); end
  endtask

  task automatic test_scroll_pass;
    int p;
    ifc.speed = 3'd1;
    run_ticks(540, p);
    checks++; if (ox(0) !== 100) begin errors++; $display("FAIL scroll540_x0: got %0d want 100", ox(0)); end
    checks++; if (p !== 0) begin errors++; $display("FAIL scroll540_pass: got %0d pulses want 0", p); end
    @(negedge clk); ifc.tick = 1'b1;
    @(negedge clk); ifc.tick = 1'b0;
    checks++; if (ox(0) !== 99) begin errors++; $display("FAIL cross_x0: got %0d want 99", ox(0)); end
    checks++; if (ifc.pass !== 1'b1) begin errors++; $display("FAIL cross_pass: got %b want 1", ifc.pass); end
    checks++; if (ifc.score !== 8'd1) begin errors++; $display("FAIL cross_score: got %0d want 1", ifc.score); end
    @(negedge clk);
    checks++; if (ifc.pass !== 1'b0) begin errors++; $display("FAIL pass_width: got %b want 0", ifc.pass); end
  endtask

  task automatic test_respawn;
    int p;
    int exp_top;
    logic [8:0] lf;
    run_ticks(99, p);
    checks++; if (ox(0) !== 0 || p !== 0) begin errors++; $display("FAIL reach_zero: got x0=%0d pulses=%0d want 0/0", ox(0), p); end
    tick_once(lf);
    exp_top = 40 + int'(lf) % 281;
    checks++; if (ox(0) !== 719) begin errors++; $display("FAIL respawn_x0: got %0d want 719", ox(0)); end
    checks++; if (ox(1) !== 239 || ox(2) !== 479) begin errors++; $display("FAIL respawn_others: got %0d,%0d want 239,479", ox(1), ox(2)); end
    checks++; if (gt(0) !== exp_top) begin errors++; $display("FAIL respawn_top: got %0d want %0d", gt(0), exp_top); end
    checks++; if (gt(0) < 40 || gt(0) > 320) begin errors++; $display("FAIL respawn_top_range: got %0d want 40..320", gt(0)); end
    checks++; if (gb(0) !== exp_top + 120) begin errors++; $display("FAIL respawn_bot: got %0d want %0d", gb(0), exp_top + 120); end
  endtask

  task automatic test_speed;
    int p;
    int exp_top;
    logic [8:0] lf;
    ifc.speed = 3'd0;
    run_ticks(10, p);
    checks++; if (ox(0) !== 709 || ox(1) !== 229) begin errors++; $display("FAIL speed0: got %0d,%0d want 709,229", ox(0), ox(1)); end
    ifc.speed = 3'd1;
    run_ticks(10, p);
    checks++; if (ox(0) !== 699 || ox(1) !== 219) begin errors++; $display("FAIL speed1: got %0d,%0d want 699,219", ox(0), ox(1)); end
    run_ticks(4, p);
    ifc.speed = 3'd7;
    run_ticks(30, p);
    checks++; if (ox(1) !== 5 || ox(0) !== 485 || ox(2) !== 245) begin errors++; $display("FAIL speed7_x: got %0d,%0d,%0d want 485,5,245", ox(0), ox(1), ox(2)); end
    checks++; if (p !== 1 || ifc.score !== 8'd2) begin errors++; $display("FAIL speed7_pass: got pulses=%0d score=%0d want 1/2", p, ifc.score); end
    tick_once(lf);
    exp_top = 40 + int'(lf) % 281;
    checks++; if (ox(1) !== 718 || ox(0) !== 478 || ox(2) !== 238) begin errors++; $display("FAIL speed7_respawn: got %0d,%0d,%0d want 478,718,238", ox(0), ox(1), ox(2)); end
    checks++; if (gt(1) !== exp_top || gb(1) !== exp_top + 120) begin errors++; $display("FAIL speed7_gap: got %0d/%0d want %0d/%0d", gt(1), gb(1), exp_top, exp_top + 120); end
  endtask

  task automatic test_freeze;
    int p;
    @(negedge clk); ifc.freeze = 1'b1; ifc.tick = 1'b1;
    @(negedge clk); ifc.freeze = 1'b0; ifc.tick = 1'b0;
    checks++; if (ifc.obs_x !== {11'd238, 11'd718, 11'd478}) begin errors++; $display("FAIL freeze_hold: got %h want %h", ifc.obs_x, {11'd238, 11'd718, 11'd478}); end
    checks++; if ({ifc.active, ifc.frozen} !== 2'b01) begin errors++; $display("FAIL freeze_flags: got %b want 01", {ifc.active, ifc.frozen}); end
    run_ticks(5, p);
    checks++; if (ifc.obs_x !== {11'd238, 11'd718, 11'd478} || p !== 0 || ifc.score !== 8'd2) begin errors++; $display("FAIL frozen_ticks: got %h p=%0d score=%0d want unchanged", ifc.obs_x, p, ifc.score); end
    @(negedge clk); ifc.run = 1'b0;
    @(negedge clk);
    checks++; if ({ifc.active, ifc.frozen} !== 2'b00) begin errors++; $display("FAIL frozen_to_idle: got %b want 00", {ifc.active, ifc.frozen}); end
    ifc.run = 1'b1;
    @(negedge clk);
    checks++; if (ifc.obs_x !== {11'd1120, 11'd880, 11'd640} || ifc.obs_gap_top !== {9'd40, 9'd40, 9'd40}) begin errors++; $display("FAIL restart_reload: got %h/%h want reset positions", ifc.obs_x, ifc.obs_gap_top); end
    checks++; if (ifc.score !== 8'd0 || ifc.active !== 1'b1) begin errors++; $display("FAIL restart_state: got score=%0d active=%b want 0/1", ifc.score, ifc.active); end
  endtask

  task automatic test_idle_hold;
    int p;
    run_ticks(3, p);
    checks++; if (ox(0) !== 619) begin errors++; $display("FAIL run_move: got %0d want 619", ox(0)); end
    @(negedge clk); ifc.run = 1'b0;
    @(negedge clk);
    checks++; if (ifc.active !== 1'b0) begin errors++; $display("FAIL run_to_idle: got %b want 0", ifc.active); end
    run_ticks(3, p);
    checks++; if (ox(0) !== 619) begin errors++; $display("FAIL idle_hold: got %0d want 619", ox(0)); end
    ifc.run = 1'b1;
    @(negedge clk);
    checks++; if (ox(0) !== 640) begin errors++; $display("FAIL idle_restart: got %0d want 640", ox(0)); end
  endtask

  task automatic test_saturation;
    int pulses = 0;
    int k = 0;
    bit got = 0;
    ifc.speed = 3'd7;
    while (k < 12000) begin
      @(negedge clk);
      if (ifc.pass === 1'b1) pulses++;
      if (ifc.score === 8'd255) break;
      ifc.tick = 1'b1;
      k++;
    end
    checks++; if (ifc.score !== 8'd255 || pulses !== 255) begin errors++; $display("FAIL reach_255: got score=%0d pulses=%0d want 255/255", ifc.score, pulses); end
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (ifc.pass === 1'b1) begin got = 1; break; end
      ifc.tick = 1'b1;
    end
    ifc.tick = 1'b0;
    checks++; if (!got || ifc.score !== 8'd255) begin errors++; $display("FAIL saturate: got pass=%0d score=%0d want 1/255", got, ifc.score); end
  endtask

  task automatic test_async_reset;
    @(negedge clk); ifc.tick = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++; if (ifc.obs_x !== {11'd1120, 11'd880, 11'd640} || ifc.obs_gap_top !== {9'd40, 9'd40, 9'd40} || ifc.obs_gap_bot !== {9'd160, 9'd160, 9'd160}) begin errors++; $display("FAIL async_reset_obs: got %h/%h/%h want reset values", ifc.obs_x, ifc.obs_gap_top, ifc.obs_gap_bot); end
    checks++; if ({ifc.active, ifc.frozen, ifc.pass} !== 3'b000 || ifc.score !== 8'd0) begin errors++; $display("FAIL async_reset_state: got flags=%b score=%0d want 000/0", {ifc.active, ifc.frozen, ifc.pass}, ifc.score); end
    ifc.tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_scroll_pass();
    test_respawn();
    test_speed();
    test_freeze();
    test_idle_hold();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
